// File: rtl/regfile_pkg.sv
// regfile_pkg: FSM state type and default geometry shared by regfile_mp files
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int B_DEF = 32;
  localparam int W_DEF = 5;
  localparam int NR_DEF = 2;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read, debug and status signals of regfile_mp
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF,
  parameter int NR = NR_DEF
) ();
  logic i_reg_write;
  logic [W-1:0] i_write_reg;
  logic [B-1:0] i_write_data;
  logic [NR*W-1:0] i_read_reg;
  logic [NR*B-1:0] o_read_data;
  logic i_dbg_req;
  logic [W-1:0] i_dbg_addr;
  logic [B-1:0] o_dbg_data;
  logic o_dbg_valid;
  logic o_busy;
  modport master (
    output i_reg_write, i_write_reg, i_write_data, i_read_reg, i_dbg_req, i_dbg_addr,
    input o_read_data, o_dbg_data, o_dbg_valid, o_busy
  );
  modport slave (
    input i_reg_write, i_write_reg, i_write_data, i_read_reg, i_dbg_req, i_dbg_addr,
    output o_read_data, o_dbg_data, o_dbg_valid, o_busy
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read mux with zero-register, busy masking and forwarding
module regfile_read_port #(
  parameter int B = 32,
  parameter int W = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit FWD = 1'b0
) (
  input  logic [W-1:0] addr,
  input  logic [B-1:0] stored,
  input  logic         busy,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  output logic [B-1:0] data
);
  logic zero;
  assign zero = busy || (ZERO_REG && addr == '0);
  assign data = zero ? '0 : (FWD && we && waddr == addr) ? wdata : stored;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-port register file with post-reset clear sweep and registered debug read
// REGFILE_FORWARD_EN enables same-cycle write-to-read forwarding on the read ports
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF,
  parameter int NR = NR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic i_clk,
  input logic i_reset,
  regfile_mp_if.slave bus
);
`ifdef REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [W:0] LAST = (W+1)'((1 << W) - 1);
  state_t state;
  logic [W:0] cnt;
  logic [B-1:0] regs [1 << W];
  logic busy;
  logic we;
  logic [W-1:0] wa;
  logic [B-1:0] wd;
  logic [B-1:0] dbg_data;
  logic dbg_valid;
  logic [B-1:0] rd [NR];
  assign busy = state == CLEAR;
  // the sweep owns the write port while busy; reset blocks every write
  always_comb begin
    we = !i_reset && (busy || (bus.i_reg_write && !(ZERO_REG && bus.i_write_reg == '0)));
    wa = busy ? cnt[W-1:0] : bus.i_write_reg;
    wd = busy ? '0 : bus.i_write_data;
  end
  always_ff @(posedge i_clk) begin
    if (we) regs[wa] <= wd;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      cnt <= '0;
      dbg_valid <= 1'b0;
      dbg_data <= '0;
    end else begin
      dbg_valid <= bus.i_dbg_req && !busy;
      if (bus.i_dbg_req && !busy) dbg_data <= regs[bus.i_dbg_addr];
      if (busy) begin
        cnt <= cnt + (W+1)'(1);
        if (cnt == LAST) state <= RUN;
      end
    end
  end
  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [W-1:0] addr;
    assign addr = bus.i_read_reg[g*W +: W];
    regfile_read_port #(.B(B), .W(W), .ZERO_REG(ZERO_REG), .FWD(FWD)) u_rd (
      .addr(addr),
      .stored(regs[addr]),
      .busy(busy),
      .we(bus.i_reg_write),
      .waddr(bus.i_write_reg),
      .wdata(bus.i_write_data),
      .data(rd[g])
    );
  end
  always_comb begin
    bus.o_read_data = '0;
    for (int i = 0; i < NR; i++) bus.o_read_data[i*B +: B] = rd[i];
  end
  assign bus.o_busy = busy;
  assign bus.o_dbg_data = dbg_data;
  assign bus.o_dbg_valid = dbg_valid;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scenario tasks with a reference model and a debug-read scoreboard queue
module tb_regfile_mp;
  import regfile_pkg::*;
  localparam int B = 32;
  localparam int W = 5;
  localparam int NR = 2;
  localparam int D = 1 << W;
`ifdef REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [B-1:0] mdl [D];
  logic [B-1:0] exp_q [$];

  regfile_mp_if #(.B(B), .W(W), .NR(NR)) bus ();
  regfile_mp #(.B(B), .W(W), .NR(NR), .ZERO_REG(1'b1)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.i_reg_write = 1'b0;
    bus.i_write_reg = '0;
    bus.i_write_data = '0;
    bus.i_dbg_req = 1'b0;
    bus.i_dbg_addr = '0;
  endtask

  task automatic set_rd(input logic [W-1:0] a0, input logic [W-1:0] a1);
    bus.i_read_reg = {a1, a0};
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d);
    bus.i_reg_write = 1'b1;
    bus.i_write_reg = a;
    bus.i_write_data = d;
    tick();
    bus.i_reg_write = 1'b0;
    if (a != '0) mdl[a] = d;
  endtask

  task automatic wait_sweep(output int cycles, output bit saw_valid);
    cycles = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_dbg_valid) saw_valid = 1'b1;
      if (!bus.o_busy) break;
      cycles++;
    end
    for (int i = 0; i < D; i++) mdl[i] = '0;
    tick();
  endtask

  task automatic test_reset;
    int cyc;
    bit sv;
    idle();
    set_rd(0, 0);
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bus.o_busy); end
    n_checks++; if (bus.o_dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_valid: got %b expected 0", bus.o_dbg_valid); end
    n_checks++; if (bus.o_dbg_data !== '0) begin n_fail++; $display("FAIL reset_dbg_data: got %h expected 0", bus.o_dbg_data); end
    n_checks++; if (bus.o_read_data !== '0) begin n_fail++; $display("FAIL reset_read_data: got %h expected 0", bus.o_read_data); end
    tick();
    rst = 1'b0;
    wait_sweep(cyc, sv);
    n_checks++; if (cyc != D) begin n_fail++; $display("FAIL reset_sweep_len: got %0d expected %0d", cyc, D); end
  endtask

  task automatic test_clear;
    int cyc;
    bit sv;
    for (int a = 1; a < D; a++) wr(W'(a), $urandom | 32'h1);
    set_rd(5, 17);
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== {mdl[17], mdl[5]}) begin n_fail++; $display("FAIL preload_read: got %h expected %h", bus.o_read_data, {mdl[17], mdl[5]}); end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_sweep(cyc, sv);
    n_checks++; if (cyc != D) begin n_fail++; $display("FAIL clear_sweep_len: got %0d expected %0d", cyc, D); end
    for (int a = 0; a < D; a++) begin
      set_rd(W'(a), W'(D - 1 - a));
      #1;
      n_checks++; if (bus.o_read_data !== '0) begin n_fail++; $display("FAIL clear_read addr %0d: got %h expected 0", a, bus.o_read_data); end
    end
    tick();
  endtask

  task automatic test_write_read;
    logic [B-1:0] exp_same;
    set_rd(7, 7);
    exp_same = FWD ? 32'hDEADBEEF : mdl[7];
    bus.i_reg_write = 1'b1;
    bus.i_write_reg = 7;
    bus.i_write_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== {exp_same, exp_same}) begin n_fail++; $display("FAIL same_cycle_read: got %h expected %h", bus.o_read_data, {exp_same, exp_same}); end
    tick();
    bus.i_reg_write = 1'b0;
    mdl[7] = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== {mdl[7], mdl[7]}) begin n_fail++; $display("FAIL next_cycle_read: got %h expected %h", bus.o_read_data, {mdl[7], mdl[7]}); end
    tick();
    wr(3, 32'h0BADF00D);
    set_rd(7, 3);
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== {mdl[3], mdl[7]}) begin n_fail++; $display("FAIL independent_ports: got %h expected %h", bus.o_read_data, {mdl[3], mdl[7]}); end
    tick();
  endtask

  task automatic test_debug;
    logic [B-1:0] held;
    bus.i_dbg_req = 1'b1;
    bus.i_dbg_addr = 7;
    exp_q.push_back(mdl[7]);
    @(negedge clk);
    n_checks++; if (bus.o_dbg_valid !== 1'b0) begin n_fail++; $display("FAIL dbg_early_valid: got %b expected 0", bus.o_dbg_valid); end
    tick();
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    held = exp_q.pop_front();
    n_checks++; if (bus.o_dbg_valid !== 1'b1) begin n_fail++; $display("FAIL dbg_valid: got %b expected 1", bus.o_dbg_valid); end
    n_checks++; if (bus.o_dbg_data !== held) begin n_fail++; $display("FAIL dbg_data: got %h expected %h", bus.o_dbg_data, held); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_dbg_valid !== 1'b0 || bus.o_dbg_data !== held) begin n_fail++; $display("FAIL dbg_hold: got %b/%h expected 0/%h", bus.o_dbg_valid, bus.o_dbg_data, held); end
    tick();
    bus.i_dbg_req = 1'b1;
    bus.i_dbg_addr = 7;
    exp_q.push_back(mdl[7]);
    wr(7, 32'h55AA55AA);
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    held = exp_q.pop_front();
    n_checks++; if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_data !== held) begin n_fail++; $display("FAIL dbg_prewrite: got %b/%h expected 1/%h", bus.o_dbg_valid, bus.o_dbg_data, held); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] addrs [4];
    logic [B-1:0] e;
    addrs = '{5'd3, 5'd7, 5'd0, 5'd7};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        bus.i_dbg_req = 1'b1;
        bus.i_dbg_addr = addrs[i];
        exp_q.push_back(mdl[addrs[i]]);
      end else bus.i_dbg_req = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_data !== e) begin n_fail++; $display("FAIL b2b_%0d: got %b/%h expected 1/%h", i - 1, bus.o_dbg_valid, bus.o_dbg_data, e); end
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_zero_reg;
    logic [B-1:0] e;
    set_rd(0, 0);
    bus.i_reg_write = 1'b1;
    bus.i_write_reg = 0;
    bus.i_write_data = 32'h1234;
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== '0) begin n_fail++; $display("FAIL zero_same_cycle: got %h expected 0", bus.o_read_data); end
    tick();
    bus.i_reg_write = 1'b0;
    bus.i_dbg_req = 1'b1;
    bus.i_dbg_addr = 0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== '0) begin n_fail++; $display("FAIL zero_next_cycle: got %h expected 0", bus.o_read_data); end
    tick();
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_data !== e) begin n_fail++; $display("FAIL zero_dbg: got %b/%h expected 1/%h", bus.o_dbg_valid, bus.o_dbg_data, e); end
    tick();
  endtask

  task automatic test_mid_sweep_reset;
    int cyc;
    bit sv;
    bit early = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.i_dbg_req = (i == 4);
      bus.i_dbg_addr = 7;
      @(negedge clk);
      if (bus.o_dbg_valid) early = 1'b1;
      tick();
    end
    bus.i_dbg_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep(cyc, sv);
    n_checks++; if (cyc != D) begin n_fail++; $display("FAIL midsweep_len: got %0d expected %0d", cyc, D); end
    n_checks++; if (early || sv) begin n_fail++; $display("FAIL busy_dbg_dropped: got valid pulse expected none"); end
  endtask

  task automatic test_write_during_sweep;
    int cyc;
    bit sv;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    bus.i_reg_write = 1'b1;
    bus.i_write_reg = 5;
    bus.i_write_data = 32'hAAAA;
    tick();
    bus.i_reg_write = 1'b0;
    wait_sweep(cyc, sv);
    set_rd(5, 5);
    @(negedge clk);
    n_checks++; if (bus.o_read_data !== {mdl[5], mdl[5]}) begin n_fail++; $display("FAIL sweep_write_ignored: got %h expected %h", bus.o_read_data, {mdl[5], mdl[5]}); end
    tick();
  endtask

  initial begin
    idle();
    set_rd(0, 0);
    test_reset();
    test_clear();
    test_write_read();
    test_debug();
    test_back_to_back();
    test_zero_reg();
    test_mid_sweep_reset();
    test_write_during_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the ID stage: NR combinational read ports, one synchronous write port, and a registered debug read port for the debug unit. It clears every register to zero with a sequential sweep after reset, and reports the sweep on `o_busy`. Register 0 can optionally be hardwired to zero. Write-to-read forwarding is compile-time selectable.

## Interface
- `B`, 32, data width in bits
- `W`, 5, address width; depth = 2**W registers
- `NR`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1 register 0 always reads zero and ignores writes

Ports:
- `i_clk` in 1: the single clock; all state updates on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_reg_write` in 1: write enable (RegWrite control line).
- `i_write_reg` in W: write address.
- `i_write_data` in B: write data.
- `i_read_reg` in NR*W: read addresses; port k occupies bits [k*W +: W].
- `o_read_data` out NR*B: read data; port k occupies bits [k*B +: B]; combinational.
- `i_dbg_req` in 1: debug read request, single-cycle pulse.
- `i_dbg_addr` in W: debug read address, sampled with `i_dbg_req`.
- `o_dbg_data` out B: registered debug data.
- `o_dbg_valid` out 1: one-cycle pulse marking `o_dbg_data` as valid.
- `o_busy` out 1: high during reset and the clear sweep.

## Operation
- **FSM states:** `CLEAR` and `RUN`.
  - `i_reset`=1 forces `CLEAR` with the sweep counter `cnt` set to 0. This takes priority over everything, including mid-sweep: the sweep restarts at 0.
  - In `CLEAR` with `i_reset`=0, each cycle writes 0 to `regs[cnt]` and increments `cnt`.
  - When `cnt` reaches 2**W-1 and that register is written, the FSM moves to `RUN`.
  - `cnt` is W+1 bits wide, so there is no wrap ambiguity.
- **Writes:**
  - In `RUN`, `i_reg_write`=1 writes `i_write_data` to `regs[i_write_reg]` at the rising edge.
  - In `CLEAR`, `i_reg_write` is ignored.
  - With `ZERO_REG`=1, a write to address 0 is discarded.
- **Reads:**
  - Each `o_read_data` port is combinational from `regs[addr]`.
  - With `ZERO_REG`=1, address 0 returns 0.
  - All ports read zero while `o_busy`=1.
  - Ports are independent; identical addresses on several ports are legal.
- **Debug port:**
  - `i_dbg_req`=1 with `o_busy`=0 registers `regs[i_dbg_addr]` into `o_dbg_data` and pulses `o_dbg_valid` on the next cycle.
  - A request while `o_busy`=1 is dropped, and no valid pulse follows.
  - The debug sample returns the pre-write value if a write to the same address occurs in the same cycle, independent of forwarding.
  - `o_dbg_data` holds its value until the next accepted request.
- **Reset values:** `o_busy`=1, `o_dbg_valid`=0, `o_dbg_data`=0, `o_read_data`=0.

## Timing
- Clear sweep: 2**W cycles after `i_reset` deasserts (32 cycles at defaults). `o_busy` falls on the edge that completes the sweep.
- Write to read visibility:
  - Without forwarding, a read sees new data in the cycle after the write edge.
  - With forwarding, a read sees it in the same cycle.
- Debug latency: exactly 1 cycle from request to `o_dbg_valid`. Back-to-back requests on consecutive cycles are each serviced.

## Configuration
- Macro: `REGFILE_FORWARD_EN`.
- **Defined:** when `o_busy`=0 and `i_reg_write`=1 and `i_write_reg` equals a port's read address, that port returns `i_write_data` in the same cycle. Forwarding does not apply to address 0 when `ZERO_REG`=1.
- **Undefined:** reads always return stored contents, and the ID stage relies on the hazard unit instead.

## Structure
- Shared package `regfile_pkg`: FSM state typedef (`CLEAR`, `RUN`) and the default B/W/NR constants.
- One natural sub-module, `regfile_read_port`: a single read mux with zero-register, busy masking and forwarding logic, instantiated NR times through a generate loop.

## Test plan
- **Reset and clear:** preload values, pulse `i_reset` for 2 cycles → `o_busy`=1 for 2+32 cycles, then every address reads 0 on all ports.
- **Mid-sweep reset:** reassert `i_reset` at sweep cycle 10 → sweep restarts, and `o_busy` stays high for a further 32 cycles after release.
- **Write and read:** write 0xDEADBEEF to reg 7, read reg 7 on ports 0 and 1 → 0xDEADBEEF next cycle. Same-cycle value is 0 without the macro, 0xDEADBEEF with it.
- **Zero register:** write 0x1234 to reg 0 → all ports and the debug port read 0. Forwarding does not produce 0x1234.
- **Debug port:** request address 7 → `o_dbg_valid` pulses 1 cycle later with data 0xDEADBEEF. A request during `o_busy` produces no pulse.
- **Write ignored during sweep:** write during `CLEAR` → the register reads 0 after the sweep.
